// File: rtl/seq_detector_param.sv
// seq_detector_param
// Serial pattern detector for a qualified 1-bit stream. The state is the
// length of the longest pattern prefix that ends the accepted stream.
// Mismatches fall back through KMP failure links. The links are resolved at
// elaboration into a constant next-state table.
// Match output is either Mealy (combinational) or Moore (registered).
// Restart after a hit is either overlapping or from empty.
// Match counter saturates at its maximum value.
// Optional feature: define SEQ_DET_FIRST_EN to add the first_vld/first_idx
// outputs. These record the stream index of the first hit after reset or clr.
module seq_detector_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter bit                 MOORE   = 1'b0,
  parameter int                 CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic                         in_valid,
  input  logic                         in_bit,
  input  logic                         clr,
  output logic                         match,
  output logic [CNT_W-1:0]             match_cnt,
  output logic [$clog2(PAT_LEN+1)-1:0] state_dbg
`ifdef SEQ_DET_FIRST_EN
  ,
  output logic                         first_vld,
  output logic [15:0]                  first_idx
`endif
);

  localparam int SW    = $clog2(PAT_LEN + 1);
  localparam int TAB_W = 2 * PAT_LEN * SW;

  // Bit of the pattern expected after a prefix of length i has been seen.
  function automatic bit pat_bit(input int i);
    return PATTERN[PAT_LEN-1-i];
  endfunction

  // Failure link: length of the longest proper border of the k-bit prefix.
  function automatic int fail_len(input int k);
    int best;
    bit ok;
    best = 0;
    for (int l = 1; l < k; l++) begin
      ok = 1'b1;
      for (int j = 0; j < l; j++)
        if (pat_bit(j) != pat_bit(k - l + j)) ok = 1'b0;
      if (ok) best = l;
    end
    return best;
  endfunction

  // Next prefix length from state s on bit b, walking failure links on mismatch.
  function automatic int kmp_step(input int s, input bit b);
    int  t;
    int  res;
    bit  done;
    t    = s;
    res  = 0;
    done = 1'b0;
    for (int n = 0; n <= PAT_LEN; n++) begin
      if (!done) begin
        if (t < PAT_LEN && pat_bit(t) == b) begin
          res  = t + 1;
          done = 1'b1;
        end else if (t == 0) begin
          done = 1'b1;
        end else begin
          t = fail_len(t);
        end
      end
    end
    return res;
  endfunction

  // Packs kmp_step for every (state, bit) pair into one constant vector.
  function automatic logic [TAB_W-1:0] build_tab();
    logic [TAB_W-1:0] tab;
    tab = '0;
    for (int s = 0; s < PAT_LEN; s++)
      for (int b = 0; b < 2; b++)
        tab[(2*s+b)*SW +: SW] = SW'(kmp_step(s, 1'(b)));
    return tab;
  endfunction

  localparam logic [TAB_W-1:0] NEXT_TAB = build_tab();
  localparam int               RESUME   = OVERLAP ? fail_len(PAT_LEN) : 0;
  localparam logic [SW-1:0]    S_FULL   = SW'(PAT_LEN);
  localparam logic [SW-1:0]    S_RESUME = SW'(RESUME);

  // The state is a prefix length, so it is kept as a number rather than an enum.
  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic [SW-1:0] eff_s;
  logic [SW-1:0] step_s;
  logic          accept;
  logic          complete;
  logic          flag_q;

  // Next-state and completion decode; PAT_LEN (Moore only) behaves as the resume state.
  always_comb begin
    // NOTE: every signal driven here gets a value before any branch, so no latch is inferred.
    accept   = in_valid & ~clr;
    eff_s    = (state_q == S_FULL) ? S_RESUME : state_q;
    step_s   = NEXT_TAB[int'({eff_s, in_bit}) * SW +: SW];
    complete = accept & (step_s == S_FULL);
    state_d  = state_q;
    if (clr) begin
      state_d = '0;
    end else if (in_valid) begin
      if (complete) state_d = MOORE ? S_FULL : S_RESUME;
      else          state_d = step_s;
    end
  end

  // Prefix-length state register.
  always_ff @(posedge clk or posedge areset) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values.
    if (areset) state_q <= '0;
    else        state_q <= state_d;
  end

  // Moore match flag and saturating match counter.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      flag_q    <= 1'b0;
      match_cnt <= '0;
    end else if (clr) begin
      flag_q    <= 1'b0;
      match_cnt <= '0;
    end else begin
      flag_q <= complete;
      if (complete && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
    end
  end

  assign match     = MOORE ? flag_q : (complete & ~areset);
  assign state_dbg = state_q;

`ifdef SEQ_DET_FIRST_EN
  logic [15:0] bit_idx;

  // Accepted-bit index and sticky capture of the first completing index.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      bit_idx   <= '0;
      first_vld <= 1'b0;
      first_idx <= '0;
    end else if (clr) begin
      bit_idx   <= '0;
      first_vld <= 1'b0;
      first_idx <= '0;
    end else if (accept) begin
      if (bit_idx != 16'hFFFF) bit_idx <= bit_idx + 16'd1;
      if (complete && !first_vld) begin
        first_vld <= 1'b1;
        first_idx <= bit_idx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param
// Six detector configurations share one input stream. A history-based
// reference model predicts every output on every cycle. Directed literal
// expectations pin the model itself.
// The first-hit outputs are checked when SEQ_DET_FIRST_EN is defined.
`timescale 1ns/1ps
module tb_seq_detector_param;

  localparam int N = 6;
  localparam int P_LEN [N] = '{4, 4, 4, 4, 5, 4};
  localparam int P_PAT [N] = '{'hB, 'hB, 'hB, 'hB, 'h1B, 'hB};
  localparam bit P_OV  [N] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam bit P_MO  [N] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam int P_CW  [N] = '{8, 8, 8, 2, 8, 8};

  logic clk = 1'b0;
  logic areset = 1'b1;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic clr = 1'b0;

  logic       match_w [N];
  logic [7:0] cnt_w   [N];
  logic [2:0] sd_w    [N];
`ifdef SEQ_DET_FIRST_EN
  logic        fv_w [N];
  logic [15:0] fi_w [N];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [P_CW[g]-1:0] cnt_l;
    seq_detector_param #(
      .PAT_LEN (P_LEN[g]),
      .PATTERN (P_PAT[g][P_LEN[g]-1:0]),
      .OVERLAP (P_OV[g]),
      .MOORE   (P_MO[g]),
      .CNT_W   (P_CW[g])
    ) u_dut (
      .clk       (clk),
      .areset    (areset),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .clr       (clr),
      .match     (match_w[g]),
      .match_cnt (cnt_l),
      .state_dbg (sd_w[g])
`ifdef SEQ_DET_FIRST_EN
      ,
      .first_vld (fv_w[g]),
      .first_idx (fi_w[g])
`endif
    );
    assign cnt_w[g] = 8'(cnt_l);
  end

  // Reference model: accepted history since reset/clr (or since a hit when not overlapping).
  logic [31:0] h_bits [N];
  int          h_len  [N];
  int          m_cnt  [N];
  bit          m_flag [N];
  bit          m_full [N];
  int          m_idx  [N];
  bit          m_fv   [N];
  int          m_fi   [N];
  int          pulses [N];
  int          checks = 0;
  int          errors = 0;

  // True when the last k bits of history equal the first k pattern bits.
  function automatic bit ends_with(input logic [31:0] h, input int hl, input int pat,
                                   input int len, input int k);
    if (hl < k) return 1'b0;
    return (h & ((32'd1 << k) - 32'd1)) == (32'(pat) >> (len - k));
  endfunction

  function automatic int next_len(input int i);
    return (h_len[i] < 31) ? h_len[i] + 1 : 31;
  endfunction

  // Whether the bit currently on in_bit would complete the pattern for model i.
  function automatic bit comp(input int i);
    return ends_with((h_bits[i] << 1) | 32'(in_bit), next_len(i), P_PAT[i], P_LEN[i], P_LEN[i]);
  endfunction

  function automatic int exp_state(input int i);
    if (P_MO[i] && m_full[i]) return P_LEN[i];
    for (int k = P_LEN[i] - 1; k > 0; k--)
      if (ends_with(h_bits[i], h_len[i], P_PAT[i], P_LEN[i], k)) return k;
    return 0;
  endfunction

  // Model state update on each clock edge, cleared asynchronously by areset.
  always @(posedge clk or posedge areset) begin
    for (int i = 0; i < N; i++) begin
      if (areset || clr) begin
        h_bits[i] <= '0;
        h_len[i]  <= 0;
        m_cnt[i]  <= 0;
        m_flag[i] <= 1'b0;
        m_full[i] <= 1'b0;
        m_idx[i]  <= 0;
        m_fv[i]   <= 1'b0;
        m_fi[i]   <= 0;
      end else if (in_valid) begin
        if (comp(i)) begin
          m_cnt[i] <= (m_cnt[i] < (1 << P_CW[i]) - 1) ? m_cnt[i] + 1 : m_cnt[i];
          if (!m_fv[i]) begin
            m_fv[i] <= 1'b1;
            m_fi[i] <= m_idx[i];
          end
        end
        m_idx[i]  <= (m_idx[i] < 65535) ? m_idx[i] + 1 : m_idx[i];
        h_bits[i] <= (comp(i) && !P_OV[i]) ? 32'd0 : ((h_bits[i] << 1) | 32'(in_bit));
        h_len[i]  <= (comp(i) && !P_OV[i]) ? 0 : next_len(i);
        m_full[i] <= P_MO[i] && comp(i);
        m_flag[i] <= P_MO[i] && comp(i);
      end else begin
        m_flag[i] <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input int dut, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, dut, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      logic em;
      em = P_MO[i] ? m_flag[i] : (!areset && in_valid && !clr && comp(i));
      check("match", i, 32'(match_w[i]), 32'(em));
      check("match_cnt", i, 32'(cnt_w[i]), m_cnt[i]);
      check("state_dbg", i, 32'(sd_w[i]), exp_state(i));
`ifdef SEQ_DET_FIRST_EN
      check("first_vld", i, 32'(fv_w[i]), 32'(m_fv[i]));
      check("first_idx", i, 32'(fi_w[i]), m_fi[i]);
`endif
      if (match_w[i] === 1'b1) pulses[i]++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit b);
    in_valid = 1'b1;
    in_bit   = b;
    clr      = 1'b0;
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    clr      = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_clr();
    in_valid = 1'b0;
    clr      = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic send_seq(input logic [31:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) send(bits[k]);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0 [N];
    for (int i = 0; i < N; i++) pulses[i] = 0;
    fork
      forever begin
        @(negedge clk);
        compare_all();
      end
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_match", 0, 32'(match_w[0]), 0);
    check("rst_cnt", 0, 32'(cnt_w[0]), 0);
    check("rst_state", 2, 32'(sd_w[2]), 0);
    areset = 1'b0;
    tick();

    // 1,0,<3 idle>,1,1,0,1,1: overlap, non-overlap, Moore, 5-bit pattern.
    for (int i = 0; i < N; i++) p0[i] = pulses[i];
    send(1'b1);
    send(1'b0);
    in_valid = 1'b0;
    tick();
    check("gap_state", 2, 32'(sd_w[2]), 2);
    tick();
    tick();
    check("gap_state", 0, 32'(sd_w[0]), 2);
    check("gap_state", 2, 32'(sd_w[2]), 2);
    send_seq(32'b11011, 5);
    idle(2);
    check("ov_cnt", 0, 32'(cnt_w[0]), 2);
    check("ov_pulses", 0, pulses[0] - p0[0], 2);
    check("ov_state", 0, 32'(sd_w[0]), 1);
    check("nov_cnt", 1, 32'(cnt_w[1]), 1);
    check("nov_pulses", 1, pulses[1] - p0[1], 1);
    check("nov_state", 1, 32'(sd_w[1]), 1);
    check("moore_cnt", 2, 32'(cnt_w[2]), 2);
    check("moore_pulses", 2, pulses[2] - p0[2], 2);
    check("moore_state", 2, 32'(sd_w[2]), 4);
    check("p5_cnt", 4, 32'(cnt_w[4]), 1);
    check("p5_state", 4, 32'(sd_w[4]), 2);
    check("moore_nov_state", 5, 32'(sd_w[5]), 1);

    // clr wins over the completing bit.
    do_clr();
    check("clr_cnt", 0, 32'(cnt_w[0]), 0);
    check("clr_state", 2, 32'(sd_w[2]), 0);
    for (int i = 0; i < N; i++) p0[i] = pulses[i];
    send_seq(32'b101, 3);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    clr      = 1'b1;
    tick();
    idle(1);
    check("clrbit_cnt", 0, 32'(cnt_w[0]), 0);
    check("clrbit_state", 0, 32'(sd_w[0]), 0);
    check("clrbit_pulses", 0, pulses[0] - p0[0], 0);
    check("clrbit_pulses", 2, pulses[2] - p0[2], 0);
    send_seq(32'b1011, 4);
    idle(2);
    check("after_clr_cnt", 0, 32'(cnt_w[0]), 1);
    check("after_clr_pulses", 0, pulses[0] - p0[0], 1);
    check("after_clr_cnt", 2, 32'(cnt_w[2]), 1);

    // Five overlapping hits against a 2-bit counter.
    do_clr();
    for (int i = 0; i < N; i++) p0[i] = pulses[i];
    send_seq(32'b1011011011011011, 16);
    idle(2);
    check("sat_cnt", 3, 32'(cnt_w[3]), 3);
    check("sat_pulses", 3, pulses[3] - p0[3], 5);
    check("wide_cnt", 0, 32'(cnt_w[0]), 5);

    // Asynchronous reset in the middle of a prefix.
    do_clr();
    send_seq(32'b101, 3);
    in_valid = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    check("arst_state", 0, 32'(sd_w[0]), 0);
    #8;
    areset = 1'b0;
    tick();
    for (int i = 0; i < N; i++) p0[i] = pulses[i];
    send(1'b1);
    idle(1);
    check("arst_resume_state", 0, 32'(sd_w[0]), 1);
    check("arst_resume_pulses", 0, pulses[0] - p0[0], 0);
    send_seq(32'b011, 3);
    idle(2);
    check("arst_hit_cnt", 0, 32'(cnt_w[0]), 1);
`ifdef SEQ_DET_FIRST_EN
    check("first_vld_lit", 0, 32'(fv_w[0]), 1);
    check("first_idx_lit", 0, 32'(fi_w[0]), 3);
`endif

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
